// File: rtl/led_display_ctrl_if.sv
// Connects the game logic to the LED display controller: display controls, the two colour
// buses, and the registered LED drive and phase indicators.
interface led_display_ctrl_if #(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned PWM_BITS = 4
);
  logic [1:0]                  mode;
  logic                        blink_enable;
  logic [NUM_LEDS-1:0]         blink_mask;
  logic [PWM_BITS-1:0]         brightness;
  logic [NUM_LEDS*COLOR_W-1:0] guess_rgb;
  logic [NUM_LEDS*COLOR_W-1:0] history_rgb;
  logic [NUM_LEDS*COLOR_W-1:0] rgb_out;
  logic                        show_phase;
  logic                        blink_phase;

  modport master (
    output mode, blink_enable, blink_mask, brightness, guess_rgb, history_rgb,
    input  rgb_out, show_phase, blink_phase
  );

  modport slave (
    input  mode, blink_enable, blink_mask, brightness, guess_rgb, history_rgb,
    output rgb_out, show_phase, blink_phase
  );
endinterface

// File: rtl/led_display_ctrl.sv
// Drives NUM_LEDS RGB LEDs from guess/history colours with display modes, per-LED blink,
// timed guess/history alternation and global PWM brightness. All outputs are registered.
module led_display_ctrl #(
  parameter int unsigned NUM_LEDS  = 4,
  parameter int unsigned COLOR_W   = 3,
  parameter int unsigned BLINK_DIV = 25000000,
  parameter int unsigned SHOW_DIV  = 50000000,
  parameter int unsigned PWM_BITS  = 4
) (
  input logic               clk,
  input logic               rst,
  led_display_ctrl_if.slave bus
);
  localparam int unsigned BLINK_CW = $clog2(BLINK_DIV);
  localparam int unsigned SHOW_CW  = $clog2(SHOW_DIV);
  localparam logic [BLINK_CW-1:0] BLINK_LAST = BLINK_CW'(BLINK_DIV - 1);
  localparam logic [SHOW_CW-1:0]  SHOW_LAST  = SHOW_CW'(SHOW_DIV - 1);
  localparam int unsigned RGB_W = NUM_LEDS * COLOR_W;

  typedef enum logic [1:0] {
    MODE_GUESS   = 2'd0,
    MODE_HISTORY = 2'd1,
    MODE_ALT     = 2'd2,
    MODE_BLANK   = 2'd3
  } mode_e;

  mode_e mode_c;

  logic [BLINK_CW-1:0] blink_cnt_q, blink_cnt_d;
  logic                blink_act_q, blink_act_d;
  logic                blink_phase_q, blink_phase_d;

  logic [SHOW_CW-1:0]  show_cnt_q, show_cnt_d;
  logic                show_act_q, show_act_d;
  logic                show_phase_q, show_phase_d;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_on_c;

  logic [RGB_W-1:0]    src_c;
  logic [NUM_LEDS-1:0] lit_c;
  logic [RGB_W-1:0]    rgb_q, rgb_d;

  assign mode_c = mode_e'(bus.mode);

  // The counters index the currently displayed cycle: the first enabled cycle shows count 0,
  // so every blink/show half-period seen at the pins is exactly DIV cycles, including the first.
  always_comb begin
    blink_act_d   = bus.blink_enable;
    blink_cnt_d   = '0;
    blink_phase_d = 1'b1;
    if (bus.blink_enable && blink_act_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
      end
    end
  end

  always_comb begin
    show_act_d   = (mode_c == MODE_ALT);
    show_cnt_d   = '0;
    show_phase_d = 1'b0;
    if ((mode_c == MODE_ALT) && show_act_q) begin
      if (show_cnt_q == SHOW_LAST) begin
        show_cnt_d   = '0;
        show_phase_d = ~show_phase_q;
      end else begin
        show_cnt_d   = show_cnt_q + 1'b1;
        show_phase_d = show_phase_q;
      end
    end
  end

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pwm_on_c  = (pwm_cnt_q < bus.brightness) || (&bus.brightness);
  end

  // Source selection is common to all LEDs; only the blink blanking is per LED.
  always_comb begin
    unique case (mode_c)
      MODE_GUESS:   src_c = bus.guess_rgb;
      MODE_HISTORY: src_c = bus.history_rgb;
      MODE_ALT:     src_c = show_phase_d ? bus.history_rgb : bus.guess_rgb;
      MODE_BLANK:   src_c = '0;
      default:      src_c = '0;
    endcase
  end

  always_comb begin
    lit_c = '0;
    rgb_d = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      lit_c[i] = pwm_on_c && !(bus.blink_enable && bus.blink_mask[i] && !blink_phase_d);
      rgb_d[i*COLOR_W +: COLOR_W] = lit_c[i] ? src_c[i*COLOR_W +: COLOR_W] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_act_q   <= 1'b0;
      blink_phase_q <= 1'b1;
      show_cnt_q    <= '0;
      show_act_q    <= 1'b0;
      show_phase_q  <= 1'b0;
      pwm_cnt_q     <= '0;
      rgb_q         <= '0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_act_q   <= blink_act_d;
      blink_phase_q <= blink_phase_d;
      show_cnt_q    <= show_cnt_d;
      show_act_q    <= show_act_d;
      show_phase_q  <= show_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      rgb_q         <= rgb_d;
    end
  end

  assign bus.rgb_out     = rgb_q;
  assign bus.show_phase  = show_phase_q;
  assign bus.blink_phase = blink_phase_q;
endmodule

// File: tb/tb_led_display_ctrl.sv
// Self-checking bench for led_display_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all outputs also compared every cycle against a run-length model.
module tb_led_display_ctrl;
  localparam int unsigned NL = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned BD = 4;
  localparam int unsigned SD = 8;
  localparam int unsigned PB = 2;

  logic clk;
  logic rst;
  int unsigned tests;
  int unsigned fails;
  logic chk_en;

  led_display_ctrl_if #(.NUM_LEDS(NL), .COLOR_W(CW), .PWM_BITS(PB)) bus ();

  led_display_ctrl #(
    .NUM_LEDS(NL), .COLOR_W(CW), .BLINK_DIV(BD), .SHOW_DIV(SD), .PWM_BITS(PB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Half-period visibility from the number of consecutive active edges (run >= 1).
  function automatic logic first_half(input int unsigned run, input int unsigned div);
    return (((run - 1) / div) % 2) == 0;
  endfunction

  function automatic logic [11:0] model_rgb(input logic [1:0] mode, input logic en,
      input logic [3:0] mask, input logic [1:0] br, input logic [11:0] g, input logic [11:0] h,
      input int unsigned pwm, input logic bvis, input logic hist);
    logic [11:0] r;
    logic [2:0] src;
    logic on;
    r = '0;
    on = (pwm < int'(br)) || (br == 2'd3);
    for (int unsigned i = 0; i < NL; i++) begin
      case (mode)
        2'd0:    src = g[i*CW +: CW];
        2'd1:    src = h[i*CW +: CW];
        2'd2:    src = hist ? h[i*CW +: CW] : g[i*CW +: CW];
        default: src = 3'd0;
      endcase
      if (on && !(en && mask[i] && !bvis)) r[i*CW +: CW] = src;
    end
    return r;
  endfunction

  // Reference model: edges since reset and run lengths of enable / mode 2.
  int unsigned e_cnt, b_run, s_run;
  logic [11:0] exp_rgb;
  logic exp_show, exp_blink;

  always @(posedge clk) begin
    if (rst) begin
      e_cnt     <= 0;
      b_run     <= 0;
      s_run     <= 0;
      exp_rgb   <= '0;
      exp_show  <= 1'b0;
      exp_blink <= 1'b1;
    end else begin
      e_cnt     <= e_cnt + 1;
      b_run     <= bus.blink_enable ? b_run + 1 : 0;
      s_run     <= (bus.mode == 2'd2) ? s_run + 1 : 0;
      exp_blink <= bus.blink_enable ? first_half(b_run + 1, BD) : 1'b1;
      exp_show  <= (bus.mode == 2'd2) ? !first_half(s_run + 1, SD) : 1'b0;
      exp_rgb   <= model_rgb(bus.mode, bus.blink_enable, bus.blink_mask, bus.brightness,
                             bus.guess_rgb, bus.history_rgb, e_cnt % (1 << PB),
                             bus.blink_enable ? first_half(b_run + 1, BD) : 1'b1,
                             (bus.mode == 2'd2) ? !first_half(s_run + 1, SD) : 1'b0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model rgb_out", bus.rgb_out, exp_rgb);
      chk("model show_phase", {11'd0, bus.show_phase}, {11'd0, exp_show});
      chk("model blink_phase", {11'd0, bus.blink_phase}, {11'd0, exp_blink});
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int unsigned cnt_on;
    int unsigned cnt_bad;
    logic found;
    tests = 0;
    fails = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    bus.mode = 2'd0;
    bus.blink_enable = 1'b0;
    bus.blink_mask = 4'b0000;
    bus.brightness = 2'd3;
    bus.guess_rgb = 12'h249;
    bus.history_rgb = 12'h492;
    step(2);
    chk_en = 1'b1;
    chk("reset rgb_out", bus.rgb_out, 12'h000);
    chk("reset show_phase", {11'd0, bus.show_phase}, 12'd0);
    chk("reset blink_phase", {11'd0, bus.blink_phase}, 12'd1);

    rst = 1'b0;
    bus.mode = 2'd0; step(1); chk("mode0", bus.rgb_out, 12'h249);
    bus.mode = 2'd1; step(1); chk("mode1", bus.rgb_out, 12'h492);
    bus.mode = 2'd3; step(1); chk("mode3", bus.rgb_out, 12'h000);

    bus.mode = 2'd2;
    for (int k = 0; k < 24; k++) begin
      step(1);
      chk("alt rgb", bus.rgb_out, (((k / 8) % 2) == 0) ? 12'h249 : 12'h492);
      chk("alt show", {11'd0, bus.show_phase}, 12'((k / 8) % 2));
    end
    step(3);
    bus.mode = 2'd0; step(1);
    chk("alt exit rgb", bus.rgb_out, 12'h249);
    chk("alt exit show", {11'd0, bus.show_phase}, 12'd0);

    bus.blink_enable = 1'b1;
    bus.blink_mask = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      step(1);
      chk("blink rgb", bus.rgb_out, (((k / 4) % 2) == 0) ? 12'h249 : 12'h241);
      chk("blink phase", {11'd0, bus.blink_phase}, (((k / 4) % 2) == 0) ? 12'd1 : 12'd0);
    end
    bus.blink_enable = 1'b0; step(1);
    chk("blink off rgb", bus.rgb_out, 12'h249);
    chk("blink off phase", {11'd0, bus.blink_phase}, 12'd1);
    bus.blink_mask = 4'b0000;

    for (int b = 0; b < 4; b++) begin
      bus.brightness = 2'(b);
      if (b == 2) continue;
      cnt_on = 0;
      cnt_bad = 0;
      step(1);
      for (int k = 0; k < 8; k++) begin
        step(1);
        if (bus.rgb_out == 12'h249) cnt_on++;
        else if (bus.rgb_out != 12'h000) cnt_bad++;
      end
      chk("pwm on count", 12'(cnt_on), (b == 0) ? 12'd0 : (b == 1) ? 12'd2 : 12'd8);
      chk("pwm bad values", 12'(cnt_bad), 12'd0);
    end
    bus.brightness = 2'd3;

    bus.mode = 2'd2;
    bus.blink_enable = 1'b1;
    bus.blink_mask = 4'b0010;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1);
      if (bus.blink_phase == 1'b0) found = 1'b1;
    end
    chk("blank phase reached", {11'd0, found}, 12'd1);
    rst = 1'b1;
    bus.blink_enable = 1'b0;
    step(1);
    chk("midrst rgb", bus.rgb_out, 12'h000);
    chk("midrst show", {11'd0, bus.show_phase}, 12'd0);
    chk("midrst blink", {11'd0, bus.blink_phase}, 12'd1);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step(1);
      chk("postrst rgb", bus.rgb_out, (k < 8) ? 12'h249 : 12'h492);
    end

    bus.mode = 2'd0;
    bus.guess_rgb = 12'hF11;
    step(1);
    chk("colour independence", bus.rgb_out, 12'hF11);

    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) bus.blink_enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) bus.blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.brightness = 2'($urandom);
      if ($urandom_range(0, 5) == 0) bus.guess_rgb = 12'($urandom);
      if ($urandom_range(0, 5) == 0) bus.history_rgb = 12'($urandom);
      step(1);
    end

    step(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_display_ctrl.md
Name: led_display_ctrl

Overview:
Parametrised successor to the fixed four-LED driver for the game board. It drives NUM_LEDS RGB LEDs from guess and history colour buses and adds four display modes, including timed guess/history alternation. It also generalises single-LED blink to a per-LED blink mask with a programmable period, and adds global PWM brightness. Sits between game logic and the RGB pins; all outputs are registered.

Parameters:
NUM_LEDS, 4, number of RGB LEDs driven
COLOR_W, 3, bits per LED colour (one bit per R/G/B element)
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)
SHOW_DIV, 50000000, clk cycles per guess/history alternation half-period (>=2)
PWM_BITS, 4, brightness resolution

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mode  in  2  0=guess, 1=history, 2=alternate guess/history, 3=blank
blink_enable  in  1  global blink enable
blink_mask  in  NUM_LEDS  bit i=1 makes LED i blink
brightness  in  PWM_BITS  PWM duty; all-ones = full on
guess_rgb  in  NUM_LEDS*COLOR_W  LED i colour at bits [i*COLOR_W +: COLOR_W]
history_rgb  in  NUM_LEDS*COLOR_W  same packing as guess_rgb
rgb_out  out  NUM_LEDS*COLOR_W  driven colours, same packing
show_phase  out  1  0=guess displayed, 1=history displayed
blink_phase  out  1  1=blinking LEDs visible, 0=blanked

Behaviour:
- Reset (rst high at posedge clk) clears all counters and sets rgb_out=0, show_phase=0, blink_phase=1. rst takes priority over all other inputs, including mid-period.
- Blink counter:
  - counts 0..BLINK_DIV-1 while blink_enable=1; at the BLINK_DIV-1 wrap it returns to 0 and blink_phase toggles.
  - blink_enable=0 holds the counter at 0 and blink_phase=1.
  - re-enabling therefore always starts with a full visible half-period.
- Show counter:
  - runs only when mode==2: counts 0..SHOW_DIV-1, toggles show_phase at wrap.
  - mode!=2 holds counter at 0 and show_phase=0.
  - entering mode 2 starts on guess for a full half-period.
- PWM counter: PWM_BITS-wide free-running, wraps 2^PWM_BITS-1 -> 0.
  - pwm_on = (pwm_cnt < brightness) OR (brightness == all-ones).
  - brightness 0 = always off.
- Source colour per LED i:
  - mode0: guess
  - mode1: history
  - mode2: show_phase ? history : guess
  - mode3: 0
- LED i output = source AND pwm_on AND NOT(blink_enable AND blink_mask[i] AND blink_phase==0).
- Latency: rgb_out is registered. A change on any input appears at rgb_out at the 1st posedge after it. Counter-driven phase changes appear on the same edge the counter wraps (phase and rgb_out update together, computed from the next-state phase).
- Simultaneous events:
  - a blink wrap and a show wrap on the same edge both take effect on that edge.
  - a mode change on a show-wrap edge follows the mode!=2 hold rule.
- Colour fields are independent; no cross-LED or cross-bit interaction. COLOR_W-bit values pass through unmodified.

Test Plan:
Bench parameters for all scenarios: NUM_LEDS=4, BLINK_DIV=4, SHOW_DIV=8, PWM_BITS=2, brightness=3, guess all LEDs=3'd1, history all=3'd2.
- Reset and modes 0/1/3:
  - after rst, rgb_out=0, show_phase=0, blink_phase=1.
  - mode=0 -> each field 1 one cycle later.
  - mode=1 -> 2.
  - mode=3 -> 0.
- Alternation: mode=2 -> rgb fields 1 for 8 cycles, then 2 for 8 cycles, repeating; show_phase toggles every 8 cycles. Switching to mode=0 mid-period -> field 1 next cycle, show_phase=0.
- Blink: mode=0, blink_enable=1, blink_mask=4'b0010 -> LED1 alternates 1/0 every 4 cycles, other LEDs constant 1. Deassert blink_enable while blanked -> LED1=1 next cycle, blink_phase=1.
- PWM: brightness=1 -> each LED field is 1 for 1 of every 4 cycles. brightness=0 -> always 0. brightness=3 -> always 1.
- Reset mid-operation: assert rst during blanked blink phase in mode 2 -> next cycle rgb_out=0, phases at reset values. After release, the full 8-cycle guess period restarts.
- Per-LED colour independence: guess LEDs 0..3 = 1,2,4,7 in mode 0 -> rgb_out = {3'd7,3'd4,3'd2,3'd1}.
